// File: rtl/ppe_mc_pkg.sv
// Shared definitions for the multi-channel partial PE: opcodes, FSM states,
// packet field positions and packet builders.
package ppe_mc_pkg;

  localparam logic OP_WEIGHT = 1'b0;
  localparam logic OP_INPUT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SEND = 2'd2,
    ST_REQ  = 2'd3
  } state_e;

  function automatic int pkt_width(input int addr_w, input int data_w);
    return addr_w + 1 + data_w;
  endfunction

  function automatic int pkt_op_bit(input int data_w);
    return data_w;
  endfunction

  function automatic int pkt_dest_lsb(input int data_w);
    return data_w + 1;
  endfunction

  // Built at 64 bits; the caller keeps the low PKT_W bits.
  function automatic logic [63:0] mk_psum_pkt(input int data_w, input int sum_w,
                                               input logic [7:0] dest,
                                               input logic [31:0] psum,
                                               input logic [4:0] j);
    logic [63:0] mask;
    logic [63:0] pkt;
    mask = (64'd1 << sum_w) - 64'd1;
    pkt  = {32'd0, psum} & mask;
    pkt  = pkt | ({59'd0, j} << sum_w);
    pkt  = pkt | ({56'd0, dest} << pkt_dest_lsb(data_w));
    return pkt;
  endfunction

  function automatic logic [63:0] mk_req_pkt(input int data_w,
                                             input logic [7:0] dest,
                                             input logic [7:0] my_id);
    logic [63:0] pkt;
    pkt = {56'd0, my_id};
    pkt = pkt | ({56'd0, dest} << pkt_dest_lsb(data_w));
    return pkt;
  endfunction

endpackage

// File: rtl/ppe_mc_window_sum.sv
// Masked adder tree: sums the weights whose window bit is set, sign-extended
// to the partial-sum width.
module ppe_window_sum #(
  parameter int FILTER_SIZE = 5,
  parameter int WEIGHT_W    = 8,
  parameter int SUM_W       = 14
) (
  input  logic [FILTER_SIZE-1:0]          window,
  input  logic [FILTER_SIZE*WEIGHT_W-1:0] weights,
  output logic signed [SUM_W-1:0]         psum
);

  logic signed [SUM_W-1:0]    acc_s;
  logic signed [WEIGHT_W-1:0] w_s;

  // Accumulate the selected taps
  always_comb begin
    acc_s = '0;
    w_s   = '0;
    for (int k = 0; k < FILTER_SIZE; k++) begin
      w_s = weights[k*WEIGHT_W +: WEIGHT_W];
      if (window[k]) begin
        acc_s = acc_s + SUM_W'(w_s);
      end else begin
        acc_s = acc_s;
      end
    end
  end

  assign psum = acc_s;

endmodule

// File: rtl/ppe_mc.sv
// Multi-channel partial PE: holds NUM_CH kernels, emits one psum packet per
// (window, channel) for each received ifmap row, then requests the next row.
module ppe_mc
  import ppe_mc_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 25,
  parameter int WEIGHT_W    = 8,
  parameter int SUM_W       = 14,
  parameter int FILTER_SIZE = 5,
  parameter int IFMAP_W     = 25,
  parameter int NUM_CH      = 2,
  parameter int SPE_BASE    = 0,
  parameter int IMEM_ID     = 10,
  parameter int MY_ID       = 0,
  parameter int PKT_W       = pkt_width(ADDR_W, DATA_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_pkt,
  output logic             busy,
  output logic             err_early
);

  localparam int NWT      = FILTER_SIZE * NUM_CH;
  localparam int OUT_DIM  = IFMAP_W - FILTER_SIZE + 1;
  localparam int WPTR_W   = $clog2(NWT + 2);
  localparam int WIDX_W   = $clog2(NWT);
  localparam int OP_BIT   = pkt_op_bit(DATA_W);
  localparam int DEST_LSB = pkt_dest_lsb(DATA_W);

  state_e state_r;
  state_e state_nxt_s;

  logic                in_ready_r;
  logic                out_valid_r;
  logic                busy_r;
  logic                err_early_r;
  logic                w_full_r;
  logic [PKT_W-1:0]    out_pkt_r;
  logic [WPTR_W-1:0]   wptr_r;
  logic [IFMAP_W-1:0]  row_r;
  logic [4:0]          j_r;
  logic [1:0]          c_r;
  logic [WEIGHT_W-1:0] wmem_r [NWT];

  logic                          in_fire_s;
  logic                          out_fire_s;
  logic                          is_input_s;
  logic                          last_pair_s;
  logic                          wr_en_s;
  logic                          wr_hi_s;
  logic [WPTR_W-1:0]             wptr_inc1_s;
  logic [WPTR_W-1:0]             wptr_inc2_s;
  logic [FILTER_SIZE-1:0]        window_s;
  logic [FILTER_SIZE*WEIGHT_W-1:0] weights_s;
  logic signed [SUM_W-1:0]       psum_s;
  logic [7:0]                    psum_dest_s;
  logic [63:0]                   psum_pkt_s;
  logic [63:0]                   req_pkt_s;
  logic                          unused_s;

  assign in_fire_s   = in_valid & in_ready_r;
  assign out_fire_s  = out_valid_r & out_ready;
  assign is_input_s  = (in_pkt[OP_BIT] == OP_INPUT);
  assign last_pair_s = (j_r == 5'(OUT_DIM - 1)) && (c_r == 2'(NUM_CH - 1));
  assign wr_en_s     = in_fire_s & ~is_input_s;
  assign wptr_inc1_s = wptr_r + WPTR_W'(1);
  assign wptr_inc2_s = wptr_r + WPTR_W'(2);
  // The upper byte of the final odd slot has nowhere to go and is dropped.
  assign wr_hi_s     = (wptr_inc1_s < WPTR_W'(NWT));

  assign window_s    = FILTER_SIZE'(row_r >> j_r);
  assign psum_dest_s = 8'(SPE_BASE) + {6'd0, c_r};
  assign psum_pkt_s  = mk_psum_pkt(DATA_W, SUM_W, psum_dest_s, 32'(psum_s), j_r);
  assign req_pkt_s   = mk_req_pkt(DATA_W, 8'(IMEM_ID), 8'(MY_ID));
  assign unused_s    = ^{in_pkt[PKT_W-1:DEST_LSB], psum_pkt_s[63:PKT_W],
                         req_pkt_s[63:PKT_W]};

  // Present the current channel's kernel to the shared adder tree
  always_comb begin
    weights_s = '0;
    for (int k = 0; k < FILTER_SIZE; k++) begin
      weights_s[k*WEIGHT_W +: WEIGHT_W] = wmem_r[WIDX_W'(int'(c_r) * FILTER_SIZE + k)];
    end
  end

  ppe_window_sum #(
    .FILTER_SIZE (FILTER_SIZE),
    .WEIGHT_W    (WEIGHT_W),
    .SUM_W       (SUM_W)
  ) u_window_sum (
    .window  (window_s),
    .weights (weights_s),
    .psum    (psum_s)
  );

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_fire_s && is_input_s && w_full_r) begin
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: state_nxt_s = ST_SEND;
      ST_SEND: begin
        if (out_fire_s) begin
          if (last_pair_s) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_CALC;
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_REQ: begin
        if (out_fire_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Kernel storage survives reset; w_full gates its use
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      wmem_r[WIDX_W'(wptr_r)] <= in_pkt[WEIGHT_W-1:0];
      if (wr_hi_s) begin
        wmem_r[WIDX_W'(wptr_inc1_s)] <= in_pkt[8 +: WEIGHT_W];
      end
    end
  end

  // Control, row/index state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_pkt_r   <= '0;
      err_early_r <= 1'b0;
      w_full_r    <= 1'b0;
      wptr_r      <= '0;
      row_r       <= '0;
      j_r         <= 5'd0;
      c_r         <= 2'd0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == ST_IDLE);
      busy_r     <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (in_fire_s) begin
            if (!is_input_s) begin
              if (wptr_inc2_s >= WPTR_W'(NWT)) begin
                wptr_r   <= '0;
                w_full_r <= 1'b1;
              end else begin
                wptr_r <= wptr_inc2_s;
              end
            end else if (w_full_r) begin
              row_r <= in_pkt[IFMAP_W-1:0];
              j_r   <= 5'd0;
              c_r   <= 2'd0;
            end else begin
              err_early_r <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          out_pkt_r   <= psum_pkt_s[PKT_W-1:0];
          out_valid_r <= 1'b1;
        end
        ST_SEND: begin
          if (out_fire_s) begin
            if (last_pair_s) begin
              out_pkt_r <= req_pkt_s[PKT_W-1:0];
            end else begin
              out_valid_r <= 1'b0;
              if (c_r == 2'(NUM_CH - 1)) begin
                c_r <= 2'd0;
                j_r <= j_r + 5'd1;
              end else begin
                c_r <= c_r + 2'd1;
              end
            end
          end
        end
        ST_REQ: begin
          if (out_fire_s) begin
            out_valid_r <= 1'b0;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_pkt   = out_pkt_r;
  assign busy      = busy_r;
  assign err_early = err_early_r;

endmodule

// File: tb/tb_ppe_mc.sv
// Scoreboard bench for ppe_mc: expected packets are queued when a row is sent
// and compared in order against packets captured on output handshakes.
module tb_ppe_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [29:0] in_pkt = 30'd0;
  logic        in_ready;
  logic        out_valid;
  logic [29:0] out_pkt;
  logic        busy;
  logic        err_early;

  int tests = 0;
  int fails = 0;

  logic [29:0] exp_q[$];
  logic [29:0] obs_q[$];
  int          wm[10];
  int          ready_mode = 0;
  int          hs_count = 0;
  int          stall_err = 0;
  int          inr_err = 0;
  bit          in_calc = 1'b0;
  bit          prev_stall = 1'b0;
  logic [29:0] prev_pkt = 30'd0;

  always #5 clk = ~clk;

  ppe_mc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pkt    (in_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pkt   (out_pkt),
    .busy      (busy),
    .err_early (err_early)
  );

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Capture handshakes, check stall stability and in_ready while computing
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_pkt !== prev_pkt)) stall_err++;
      if (in_calc && in_ready) inr_err++;
      if (out_valid && out_ready) begin
        obs_q.push_back(out_pkt);
        hs_count++;
        if (out_pkt[29:26] == 4'd10) in_calc = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      prev_pkt   = out_pkt;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [29:0] mk_psum(input int dest, input int psum, input int j);
    logic [13:0] p;
    logic [4:0]  jj;
    logic [3:0]  d;
    p  = psum[13:0];
    jj = j[4:0];
    d  = dest[3:0];
    return {d, 1'b0, 6'd0, jj, p};
  endfunction

  task automatic push_row(input logic [24:0] row);
    int s;
    for (int j = 0; j < 21; j++) begin
      for (int c = 0; c < 2; c++) begin
        s = 0;
        for (int k = 0; k < 5; k++) if (row[j+k]) s += wm[c*5+k];
        exp_q.push_back(mk_psum(c, s, j));
      end
    end
    exp_q.push_back({4'd10, 1'b0, 25'd0});
  endtask

  task automatic send_pkt(input logic op, input logic [24:0] data, input bit computes);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_pkt   = {4'd3, op, data};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (ok && computes) in_calc = 1'b1;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_accept: in_ready got %0b, required 1", in_ready);
    end
  endtask

  task automatic load_weights();
    logic [7:0] lo;
    logic [7:0] hi;
    wm = '{1, 2, 3, 4, 5, -1, -2, -3, -4, -5};
    for (int p = 0; p < 5; p++) begin
      lo = 8'(wm[2*p]);
      hi = 8'(wm[2*p+1]);
      send_pkt(1'b0, {9'd0, hi, lo}, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_calc = 1'b0;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_stream(input string name);
    logic [29:0] e;
    logic [29:0] o;
    int waited;
    int idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      waited = 0;
      while (obs_q.size() == 0 && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      if (obs_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s_timeout: packet %0d not seen, %0d still expected", name, idx, exp_q.size());
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL %s_pkt%0d: got %h, required %h", name, idx, o, e);
      end
      idx++;
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL %s_extra: got %0d extra packets, required 0", name, obs_q.size());
      obs_q.delete();
    end
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: in_ready=%b busy=%b, required 1/0", name, in_ready, busy);
    end
    tests++;
    if (stall_err != 0 || inr_err != 0) begin
      fails++;
      $display("FAIL %s_hold: stall_err=%0d inr_err=%0d, required 0/0", name, stall_err, inr_err);
      stall_err = 0;
      inr_err = 0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, busy, err_early} !== 4'b0000 || out_pkt !== 30'd0) begin
      fails++;
      $display("FAIL reset_state: rdy/vld/busy/err=%b%b%b%b pkt=%h, required 0000 0",
               in_ready, out_valid, busy, err_early, out_pkt);
    end
    do_reset();
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_weights();
    load_weights();
    repeat (3) @(negedge clk);
    tests++;
    if (obs_q.size() != 0 || out_valid !== 1'b0 || err_early !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL weights_quiet: outs=%0d vld=%b err=%b busy=%b, required 0/0/0/0",
               obs_q.size(), out_valid, err_early, busy);
    end
  endtask

  task automatic test_all_ones();
    push_row(25'h1FF_FFFF);
    send_pkt(1'b1, 25'h1FF_FFFF, 1'b1);
    check_stream("all_ones");
  endtask

  task automatic test_single_bit();
    push_row(25'h000_0010);
    send_pkt(1'b1, 25'h000_0010, 1'b1);
    check_stream("bit4");
  endtask

  task automatic test_random_ready();
    ready_mode = 1;
    push_row(25'h000_0010);
    send_pkt(1'b1, 25'h000_0010, 1'b1);
    check_stream("rand_ready");
    ready_mode = 0;
  endtask

  task automatic test_overwrite();
    logic [24:0] row;
    send_pkt(1'b0, {9'd0, 8'hF9, 8'h09}, 1'b0);
    wm[0] = 9;
    wm[1] = -7;
    row = 25'($urandom);
    push_row(row);
    send_pkt(1'b1, row, 1'b1);
    check_stream("overwrite");
  endtask

  task automatic test_early();
    do_reset();
    send_pkt(1'b1, 25'h1FF_FFFF, 1'b0);
    repeat (4) @(negedge clk);
    tests++;
    if (err_early !== 1'b1 || obs_q.size() != 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL early_input: err=%b outs=%0d vld=%b, required 1/0/0",
               err_early, obs_q.size(), out_valid);
    end
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL early_idle: in_ready=%b busy=%b, required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    do_reset();
    load_weights();
    hs_count = 0;
    send_pkt(1'b1, 25'h1FF_FFFF, 1'b1);
    waited = 0;
    while (hs_count < 9 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    ready_mode = 2;
    @(posedge clk);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!out_valid && waited < 50);
    tests++;
    if (!out_valid || hs_count != 9) begin
      fails++;
      $display("FAIL mid_reach: vld=%b handshakes=%0d, required 1/9", out_valid, hs_count);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_pkt !== 30'd0) begin
      fails++;
      $display("FAIL mid_reset: vld=%b busy=%b rdy=%b pkt=%h, required 0/0/0/0",
               out_valid, busy, in_ready, out_pkt);
    end
    in_calc = 1'b0;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (err_early !== 1'b0) begin
      fails++;
      $display("FAIL mid_err_clear: err_early=%b, required 0", err_early);
    end
    send_pkt(1'b1, 25'h000_0010, 1'b0);
    repeat (4) @(negedge clk);
    tests++;
    if (err_early !== 1'b1 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL mid_no_weights: err=%b outs=%0d, required 1/0", err_early, obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_weights();
    test_all_ones();
    test_single_bit();
    test_random_ready();
    test_overwrite();
    test_early();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
